// File: rtl/thor2022_store_drain_if.sv
// rtl/thor2022_store_drain_if.sv - single-beat write bus between the store drain and the bus interface unit
//
// Signals: cyc_o/stb_o/we_o cycle, strobe and write enable; sel_o 16 byte lanes;
// adr_o 16-byte aligned address; dat_o 128-bit write data; ack_i/err_i bus replies.
// master: store drain side. slave: bus interface unit side.
`timescale 1ns/1ps

interface thor2022_store_drain_if #(
    parameter int AWID = 32
);
    logic             cyc_o;
    logic             stb_o;
    logic             we_o;
    logic [15:0]      sel_o;
    logic [AWID-1:0]  adr_o;
    logic [127:0]     dat_o;
    logic             ack_i;
    logic             err_i;

    modport master (
        output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        input  ack_i, err_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        output ack_i, err_i
    );
endinterface

// File: rtl/thor2022_store_drain.sv
// rtl/thor2022_store_drain.sv - pops memory request queue head and writes stores as 1-3 bus beats
//
// Ports: clk, rst_n (async active-low); q_valid/q_req/q_rd queue head and pop strobe;
// bus (thor2022_store_drain_if.master) write cycle to the bus interface unit;
// done/done_tid/done_err per-entry completion report; busy high outside IDLE.
// Optional macro THOR_DRAIN_TIMEOUT_EN: strobe held TO_CYCLES clocks without a reply ends as an error.
`timescale 1ns/1ps

package thor2022_store_drain_pkg;
    typedef enum logic [3:0] {
        MR_NOP   = 4'd0,
        MR_LOAD  = 4'd1,
        MR_STORE = 4'd2,
        MR_FENCE = 4'd3
    } mem_func_t;

    typedef enum logic [2:0] {
        byt      = 3'd0,
        wyde     = 3'd1,
        tetra    = 3'd2,
        octa     = 3'd3,
        hexi     = 3'd4,
        hexipair = 3'd5
    } mem_sz_t;

    typedef struct packed {
        mem_func_t    func;
        mem_sz_t      sz;
        logic [63:0]  adr;
        logic [255:0] dat;
        logic [7:0]   tid;
    } MemoryRequest;
endpackage

module thor2022_store_drain
    import thor2022_store_drain_pkg::*;
#(
    parameter int AWID      = 32,
    parameter int TO_CYCLES = 63
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          q_valid,
    input  MemoryRequest                  q_req,
    output logic                          q_rd,
    thor2022_store_drain_if.master        bus,
    output logic                          done,
    output logic [7:0]                    done_tid,
    output logic                          done_err,
    output logic                          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP, SETTLE} state_t;

    state_t           state, state_n;
    logic [1:0]       beat, beat_n;
    logic             gap, gap_n;      // one-cycle strobe drop between beats
    logic             capture;
    logic             complete;        // entering RESP this cycle
    logic             err_n;

    logic [47:0]      sel48;
    logic [383:0]     dat384;
    logic [AWID-5:0]  badr;
    logic [7:0]       tid_r;

    logic [15:0]      cur_sel;
    logic [127:0]     cur_dat;
    logic [AWID-5:0]  cur_badr;
    logic             has_next;
    logic             strobe;
    logic             timeout;

    logic [47:0]      cap_sel;
    logic [383:0]     cap_dat;

    logic             unused_adr_hi;
    assign unused_adr_hi = ^q_req.adr[63:AWID];

    function automatic logic [31:0] fn_sel(input mem_sz_t sz);
        case (sz)
            byt:      fn_sel = 32'h0000_0001;
            wyde:     fn_sel = 32'h0000_0003;
            tetra:    fn_sel = 32'h0000_000F;
            octa:     fn_sel = 32'h0000_00FF;
            hexi:     fn_sel = 32'h0000_FFFF;
            hexipair: fn_sel = 32'hFFFF_FFFF;
            default:  fn_sel = 32'h0000_00FF;
        endcase
    endfunction

    // Lanes are laid out across three 16-byte beats so a misaligned access
    // spills naturally into the following beats.
    assign cap_sel = {16'h0, fn_sel(q_req.sz)} << q_req.adr[3:0];
    assign cap_dat = {128'h0, q_req.dat} << {q_req.adr[3:0], 3'b000};

    always_comb begin
        cur_sel  = 16'h0;
        cur_dat  = 128'h0;
        has_next = 1'b0;
        case (beat)
            2'd0: begin
                cur_sel  = sel48[15:0];
                cur_dat  = dat384[127:0];
                has_next = |sel48[31:16];
            end
            2'd1: begin
                cur_sel  = sel48[31:16];
                cur_dat  = dat384[255:128];
                has_next = |sel48[47:32];
            end
            2'd2: begin
                cur_sel  = sel48[47:32];
                cur_dat  = dat384[383:256];
            end
            default: ;
        endcase
    end

    // Wraps modulo 2^(AWID-4) by width.
    assign cur_badr = badr + (AWID-4)'(beat);
    assign strobe   = (state == ISSUE) && !gap;

`ifdef THOR_DRAIN_TIMEOUT_EN
    localparam int TOW = $clog2(TO_CYCLES + 1);
    logic [TOW-1:0] to_cnt;

    // Counter is held at zero while strobe is low, so it restarts on every strobe rise.
    assign timeout = strobe && !bus.ack_i && !bus.err_i && (to_cnt == TOW'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!strobe) begin
            to_cnt <= '0;
        end else if (!bus.ack_i && !bus.err_i) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= 2'd0;
            gap   <= 1'b0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
            gap   <= gap_n;
        end
    end

    always_comb begin
        state_n  = state;
        beat_n   = beat;
        gap_n    = gap;
        capture  = 1'b0;
        complete = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (q_valid) begin
                    capture = 1'b1;
                    beat_n  = 2'd0;
                    gap_n   = 1'b0;
                    if (q_req.func == MR_STORE) begin
                        state_n = ISSUE;
                    end else begin
                        state_n  = RESP;
                        complete = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (gap) begin
                    gap_n = 1'b0;
                end else if (bus.err_i || timeout) begin
                    state_n  = RESP;
                    complete = 1'b1;
                    err_n    = 1'b1;
                end else if (bus.ack_i) begin
                    if (has_next) begin
                        beat_n = beat + 2'd1;
                        gap_n  = 1'b1;
                    end else begin
                        state_n  = RESP;
                        complete = 1'b1;
                    end
                end
            end
            RESP:    state_n = SETTLE;
            SETTLE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel48    <= '0;
            dat384   <= '0;
            badr     <= '0;
            tid_r    <= '0;
            done_tid <= '0;
            done_err <= 1'b0;
        end else begin
            if (capture) begin
                sel48  <= cap_sel;
                dat384 <= cap_dat;
                badr   <= q_req.adr[AWID-1:4];
                tid_r  <= q_req.tid;
            end
            if (complete) begin
                // Non-store entries complete straight from IDLE, before tid_r is loaded.
                done_tid <= (state == IDLE) ? q_req.tid : tid_r;
                done_err <= err_n;
            end
        end
    end

    // Gate with rst_n so an entry is never popped while the block is held in reset.
    assign q_rd      = rst_n && (state == IDLE) && q_valid;
    assign bus.cyc_o = (state == ISSUE);
    assign bus.stb_o = strobe;
    assign bus.we_o  = (state == ISSUE);
    assign bus.sel_o = (state == ISSUE) ? cur_sel : 16'h0;
    assign bus.adr_o = (state == ISSUE) ? {cur_badr, 4'h0} : '0;
    assign bus.dat_o = (state == ISSUE) ? cur_dat : 128'h0;
    assign done      = (state == RESP);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_thor2022_store_drain.sv
// tb/tb_thor2022_store_drain.sv - scoreboard bench for thor2022_store_drain
`timescale 1ns/1ps

module tb_thor2022_store_drain;
    import thor2022_store_drain_pkg::*;

    localparam int AWID = 32;
`ifdef THOR_DRAIN_TIMEOUT_EN
    localparam int TO_C = 8;
`else
    localparam int TO_C = 63;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         q_valid;
    MemoryRequest q_req;
    logic         q_rd;
    logic         done;
    logic [7:0]   done_tid;
    logic         done_err;
    logic         busy;

    thor2022_store_drain_if #(.AWID(AWID)) bus ();

    thor2022_store_drain #(.AWID(AWID), .TO_CYCLES(TO_C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .q_valid  (q_valid),
        .q_req    (q_req),
        .q_rd     (q_rd),
        .bus      (bus),
        .done     (done),
        .done_tid (done_tid),
        .done_err (done_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  adr;
        logic [15:0]  sel;
        logic [127:0] dat;
    } beat_t;

    typedef struct {
        logic [7:0] tid;
        logic       err;
    } done_t;

    beat_t        exp_beats[$];
    done_t        exp_done[$];
    MemoryRequest stim[$];
    int           pop_times[$];

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input mem_func_t f, input mem_sz_t s, input logic [31:0] a,
                        input logic [255:0] d, input logic [7:0] t);
        MemoryRequest r;
        r.func = f;
        r.sz   = s;
        r.adr  = {32'h0, a};
        r.dat  = d;
        r.tid  = t;
        stim.push_back(r);
    endtask

    task automatic exp_beat(input logic [31:0] a, input logic [15:0] s, input logic [127:0] d);
        beat_t b;
        b.adr = a;
        b.sel = s;
        b.dat = d;
        exp_beats.push_back(b);
    endtask

    task automatic exp_fin(input logic [7:0] t, input logic e);
        done_t x;
        x.tid = t;
        x.err = e;
        exp_done.push_back(x);
    endtask

    always @(posedge clk) cycle++;

    // Queue head model: presents entries in order, drops valid after each pop.
    logic pop_pending = 1'b0;
    initial begin
        q_valid = 1'b0;
        q_req   = '0;
        forever begin
            @(negedge clk);
            if (pop_pending) begin
                q_valid     = 1'b0;
                pop_pending = 1'b0;
            end
            if (!q_valid && stim.size() > 0) begin
                q_req   = stim.pop_front();
                q_valid = 1'b1;
            end
            #1;
            if (q_valid && q_rd) begin
                pop_pending = 1'b1;
                pop_times.push_back(cycle);
            end
        end
    end

    // Bus responder.
    int lat = 2;
    int err_beat = -1;
    bit noack = 1'b0;
    int rcnt = 0;
    int rbeat = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.ack_i = 1'b0;
            bus.err_i = 1'b0;
            rcnt      = 0;
            rbeat     = 0;
        end else if (bus.ack_i || bus.err_i) begin
            bus.ack_i = 1'b0;
            bus.err_i = 1'b0;
            rcnt      = 0;
        end else if (bus.stb_o && !noack) begin
            if (rcnt >= lat) begin
                if (rbeat == err_beat) bus.err_i = 1'b1;
                else                   bus.ack_i = 1'b1;
                rbeat++;
            end else begin
                rcnt++;
            end
        end
        if (done) rbeat = 0;
    end

    // Monitor: compares each new strobe and each done pulse against the scoreboard.
    logic stb_q = 1'b0;
    logic cyc_q = 1'b0;
    int   stb_rises = 0;
    int   cyc_falls = 0;
    int   done_cnt = 0;
    int   stb_hi = 0;
    always @(negedge clk) begin
        if (bus.stb_o && !stb_q) begin
            stb_rises++;
            stb_hi = 0;
            if (exp_beats.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got adr %0h sel %0h expected no beat", bus.adr_o, bus.sel_o);
            end else begin
                beat_t b;
                b = exp_beats.pop_front();
                chk("beat_adr", 256'(bus.adr_o), 256'(b.adr));
                chk("beat_sel", 256'(bus.sel_o), 256'(b.sel));
                chk("beat_dat", 256'(bus.dat_o), 256'(b.dat));
                chk("beat_we",  256'(bus.we_o & bus.cyc_o), 256'(1));
            end
        end
        if (bus.stb_o) stb_hi++;
        if (cyc_q && !bus.cyc_o) cyc_falls++;
        if (done) begin
            done_cnt++;
            if (exp_done.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got tid %0h expected no done", done_tid);
            end else begin
                done_t x;
                x = exp_done.pop_front();
                chk("done_tid", 256'(done_tid), 256'(x.tid));
                chk("done_err", 256'(done_err), 256'(x.err));
            end
        end
        stb_q = bus.stb_o;
        cyc_q = bus.cyc_o;
    end

    task automatic wait_quiet(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!(stim.size() == 0 && !q_valid && exp_done.size() == 0 && !busy) && n < budget);
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got still busy after %0d cycles expected idle", name, budget);
        end
    endtask

    task automatic wait_rises(input int target, input int budget);
        int n = 0;
        while (stb_rises < target && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (stb_rises < target) begin
            checks++;
            errors++;
            $display("FAIL stb_wait: got %0d strobes expected %0d", stb_rises, target);
        end
    endtask

    int base_falls;
    int base_done;
    int base_rises;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_q_rd",     256'(q_rd), 256'(0));
        chk("rst_cyc",      256'(bus.cyc_o), 256'(0));
        chk("rst_stb",      256'(bus.stb_o), 256'(0));
        chk("rst_we",       256'(bus.we_o), 256'(0));
        chk("rst_sel",      256'(bus.sel_o), 256'(0));
        chk("rst_adr",      256'(bus.adr_o), 256'(0));
        chk("rst_dat",      256'(bus.dat_o), 256'(0));
        chk("rst_done",     256'(done), 256'(0));
        chk("rst_done_tid", 256'(done_tid), 256'(0));
        chk("rst_done_err", 256'(done_err), 256'(0));
        chk("rst_busy",     256'(busy), 256'(0));
        rst_n = 1'b1;

        // Octa at 0x1008: upper half of one beat.
        base_falls = cyc_falls;
        exp_beat(32'h1000, 16'hFF00, 128'h1122334455667788_0000000000000000);
        exp_fin(8'h11, 1'b0);
        push(MR_STORE, octa, 32'h1008, 256'h1122334455667788, 8'h11);
        wait_quiet("octa", 50);
        repeat (3) @(negedge clk);
        chk("octa_cyc_falls", 256'(cyc_falls - base_falls), 256'(1));
        chk("hold_done_tid",  256'(done_tid), 256'(8'h11));
        chk("hold_done_err",  256'(done_err), 256'(0));

        // Hexi at 0x2004: two beats under a single cycle.
        base_falls = cyc_falls;
        base_done  = done_cnt;
        exp_beat(32'h2000, 16'hFFF0, 128'h44556677_8899AABB_CCDDEEFF_00000000);
        exp_beat(32'h2010, 16'h000F, 128'h00112233);
        exp_fin(8'h22, 1'b0);
        push(MR_STORE, hexi, 32'h2004, 256'h00112233_44556677_8899AABB_CCDDEEFF, 8'h22);
        wait_quiet("hexi", 60);
        chk("hexi_cyc_falls", 256'(cyc_falls - base_falls), 256'(1));
        chk("hexi_done_cnt",  256'(done_cnt - base_done), 256'(1));

        // Hexipair at 0x300C: three beats.
        exp_beat(32'h3000, 16'hF000, 128'h03020100_00000000_00000000_00000000);
        exp_beat(32'h3010, 16'hFFFF, 128'h13121110_0F0E0D0C_0B0A0908_07060504);
        exp_beat(32'h3020, 16'h0FFF, 128'h00000000_1F1E1D1C_1B1A1918_17161514);
        exp_fin(8'h33, 1'b0);
        push(MR_STORE, hexipair, 32'h300C,
             256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100, 8'h33);
        wait_quiet("hexipair", 80);

        // Byte at the top of a half, tetra straddling a 16-byte boundary.
        exp_beat(32'h5000, 16'h0080, 128'h0000000000000000AB00000000000000);
        exp_fin(8'h55, 1'b0);
        push(MR_STORE, byt, 32'h5007, 256'hAB, 8'h55);
        exp_beat(32'h6000, 16'hC000, 128'hCDEF0000000000000000000000000000);
        exp_beat(32'h6010, 16'h0003, 128'h89AB);
        exp_fin(8'h66, 1'b0);
        push(MR_STORE, tetra, 32'h600E, 256'h89ABCDEF, 8'h66);
        wait_quiet("byt_tetra", 100);

        // Bus error on beat 0 of a two-beat store, then a load right behind it.
        base_falls = cyc_falls;
        pop_times.delete();
        err_beat = 0;
        exp_beat(32'h4000, 16'hFF00, 128'h01234567_89ABCDEF_00000000_00000000);
        exp_fin(8'h44, 1'b1);
        exp_fin(8'h45, 1'b0);
        push(MR_STORE, hexi, 32'h4008, 256'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 8'h44);
        push(MR_LOAD, octa, 32'h4100, 256'h0, 8'h45);
        wait_quiet("err", 60);
        err_beat = -1;
        chk("err_cyc_falls", 256'(cyc_falls - base_falls), 256'(1));
        if (pop_times.size() == 2) chk("err_pop_spacing", 256'(pop_times[1] - pop_times[0]), 256'(6));
        else chk("err_pop_count", 256'(pop_times.size()), 256'(2));

        // Back-to-back single-beat stores with zero-wait ack: 4-clock pop spacing.
        lat = 0;
        pop_times.delete();
        exp_beat(32'h9000, 16'h00FF, 128'h91);
        exp_fin(8'h91, 1'b0);
        exp_beat(32'h9010, 16'h00FF, 128'h92);
        exp_fin(8'h92, 1'b0);
        push(MR_STORE, octa, 32'h9000, 256'h91, 8'h91);
        push(MR_STORE, octa, 32'h9010, 256'h92, 8'h92);
        wait_quiet("spacing", 40);
        if (pop_times.size() == 2) chk("min_pop_spacing", 256'(pop_times[1] - pop_times[0]), 256'(4));
        else chk("spacing_pop_count", 256'(pop_times.size()), 256'(2));

        // Reset during beat 1: cycle drops at once, no done, next entry drains normally.
        lat = 1;
        base_done  = done_cnt;
        base_rises = stb_rises;
        exp_beat(32'h7000, 16'hFF00, 128'h090A0B0C0D0E0F10_0000000000000000);
        exp_beat(32'h7010, 16'h00FF, 128'h0102030405060708);
        push(MR_STORE, hexi, 32'h7008, 256'h0102030405060708_090A0B0C0D0E0F10, 8'h77);
        wait_rises(base_rises + 2, 40);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc",  256'(bus.cyc_o), 256'(0));
        chk("rst_mid_busy", 256'(busy), 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_no_done", 256'(done_cnt - base_done), 256'(0));
        chk("rst_mid_tid",     256'(done_tid), 256'(0));
        exp_beat(32'h7100, 16'h00FF, 128'hCAFE);
        exp_fin(8'h78, 1'b0);
        push(MR_STORE, octa, 32'h7100, 256'hCAFE, 8'h78);
        wait_quiet("after_rst", 40);

        // Bus that never acknowledges.
        lat = 2;
        noack = 1'b1;
        base_rises = stb_rises;
        exp_beat(32'h8000, 16'h00FF, 128'h1);
        push(MR_STORE, octa, 32'h8000, 256'h1, 8'h88);
`ifdef THOR_DRAIN_TIMEOUT_EN
        exp_fin(8'h88, 1'b1);
        wait_quiet("timeout", 60);
        chk("timeout_stb_cycles", 256'(stb_hi), 256'(TO_C));
`else
        wait_rises(base_rises + 1, 20);
        repeat (100) @(negedge clk);
        #2;
        chk("noack_cyc_held", 256'(bus.cyc_o), 256'(1));
        chk("noack_stb_held", 256'(bus.stb_o), 256'(1));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`endif
        noack = 1'b0;
        repeat (4) @(negedge clk);

        chk("leftover_beats", 256'(exp_beats.size()), 256'(0));
        chk("leftover_done",  256'(exp_done.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/thor2022_store_drain.md
Name: thor2022_store_drain

Overview:
- Consumer end of the memory request queue: pops the head entry (rd/o/valid) and writes it to the 128-bit data bus as one to three single-beat write cycles.
- Sits between the request queue and the bus interface unit.
- Reports completion per transaction ID back to the pipeline.

Parameters:
- AWID, 32, address width in bits.
- TO_CYCLES, 63, bus-ack timeout in clocks; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- q_valid  in  1  queue head valid.
- q_req  in  MemoryRequest  queue head entry; func, sz, adr, dat, tid used.
- q_rd  out  1  pop strobe to queue; one-cycle pulse.
- cyc_o  out  1  bus cycle.
- stb_o  out  1  bus strobe.
- we_o  out  1  write enable.
- sel_o  out  16  byte lane selects.
- adr_o  out  AWID  bus address; low 4 bits always 0.
- dat_o  out  128  write data.
- ack_i  in  1  bus acknowledge.
- err_i  in  1  bus error.
- done  out  1  one-cycle completion pulse.
- done_tid  out  8  tid of the completed entry.
- done_err  out  1  entry ended in error (bus error or timeout).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE. q_rd, cyc_o, stb_o, we_o, done, done_err, busy = 0. sel_o = 0, adr_o = 0, dat_o = 0, done_tid = 0.
- Reset mid-transaction drops cyc_o immediately. The entry is lost and no done is issued.
- Lane math, computed on capture:
  - sel48 = fnSel(sz) zero-extended to 48 bits, shifted left by adr[3:0].
  - fnSel: byt=1, wyde=3, tetra=F, octa=FF, hexi=FFFF, hexipair=FFFFFFFF, other=FF.
  - dat384 = dat zero-extended to 384 bits, shifted left by adr[3:0]*8.
  - Beat k (k=0..2): sel=sel48[16k+15:16k], data=dat384[128k+127:128k], address={adr[AWID-1:4]+k, 4'h0}.
  - Address increment wraps modulo 2^(AWID-4).
  - Beats with sel==0 are skipped.
- States:
  - IDLE: if q_valid, assert q_rd for one cycle, capture q_req and compute lanes, then go to ISSUE.
  - ISSUE: drive cyc_o=stb_o=we_o=1 with the current beat's sel/adr/dat. Hold until ack_i or err_i.
    - ack_i: advance to the next non-empty beat (stay in ISSUE, cyc_o stays high between beats, stb_o drops for 1 cycle); if no beats remain, go to RESP.
    - err_i: abandon remaining beats, set done_err=1, go to RESP.
    - If ack_i and err_i are asserted together, err_i wins.
  - RESP: drop cyc/stb/we. Pulse done with done_tid. Go to SETTLE.
  - SETTLE: one idle cycle so the queue's registered head output reflects the pop. Then go to IDLE.
- Non-store entries (func != MR_STORE): popped, no bus cycle; RESP with done_err=0.
- Minimum pop-to-pop spacing is 4 clocks for a single-beat store.
- q_valid dropping while in a non-IDLE state is ignored; the captured copy is used.
- done_tid/done_err hold their value until the next done.

Optional Feature:
- Macro THOR_DRAIN_TIMEOUT_EN.
- Defined: a counter clears at each stb_o rising edge and counts while stb_o is high without ack_i/err_i. When it reaches TO_CYCLES, the block treats it as err_i (drops cyc, done_err=1).
- Undefined: no counter; the block waits on ack_i indefinitely.

Test Plan:
- Octa store, adr=0x1008, dat=0x1122334455667788, ack after 2 clocks -> single beat, adr_o=0x1000, sel_o=FF00, dat_o[127:64]=0x1122334455667788; done with done_tid matching and done_err=0.
- Hexi store, adr=0x2004 -> two beats: (0x2000, sel FFF0) then (0x2010, sel 000F); cyc_o stays high across both beats; one done pulse.
- Hexipair store, adr=0x300C -> three beats at 0x3000/0x3010/0x3020 with sels F000/FFFF/0FFF.
- err_i on beat 0 of a two-beat store -> no second beat; done_err=1; the next entry is popped after SETTLE.
- With THOR_DRAIN_TIMEOUT_EN and TO_CYCLES=8, ack_i held low -> cyc_o drops after 8 strobe cycles and done_err=1. Without the macro, cyc_o is still high at cycle 100.
- rst_n pulled low during beat 1 -> cyc_o goes to 0 the same cycle, no done; after release the block is in IDLE and pops the next q_valid entry.
